// File: rtl/midi_tx.sv
// MIDI OUT transmitter: one note-on/note-off command per handshake, sent as 8N1 UART
// bytes with optional running-status suppression of a repeated status byte.
module midi_tx #(
  parameter int CLK_FREQ       = 50000000,
  parameter int BAUD           = 31250,
  parameter int RUNNING_STATUS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_note_on,
  input  logic [3:0] cmd_ch,
  input  logic [6:0] cmd_d1,
  input  logic [6:0] cmd_d2,
  output logic       tx,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state_r, state_s;
  logic [CW-1:0] baud_r, baud_s;
  logic [2:0]    bit_r, bit_s;
  logic [1:0]    idx_r, idx_s;
  logic [7:0]    status_r;
  logic [6:0]    d1_r, d2_r;
  logic [7:0]    last_status_r;
  logic          last_valid_r;
  logic          tx_r, tx_s;
  logic          ready_r, busy_r;
  logic          accept_s, skip_s;
  logic [7:0]    new_status_s, cur_byte_s;

  // Message byte selected by index: 0 = status, 1 = key, 2 = velocity.
  function automatic logic [7:0] byte_sel(input logic [1:0] idx, input logic [7:0] s,
                                          input logic [6:0] d1, input logic [6:0] d2);
    logic [7:0] r;
    case (idx)
      2'd0:    r = s;
      2'd1:    r = {1'b0, d1};
      default: r = {1'b0, d2};
    endcase
    return r;
  endfunction

  assign accept_s     = cmd_valid && ready_r;
  assign new_status_s = {1'b1, 2'b00, cmd_note_on, cmd_ch};
  assign skip_s       = (RUNNING_STATUS != 0) && last_valid_r && (new_status_s == last_status_r);
  assign cmd_ready    = ready_r;
  assign busy         = busy_r;
  assign tx           = tx_r;

  // Next-state, counters and the next serial bit (tx is registered from tx_s).
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = START;
          baud_s  = '0;
          bit_s   = 3'd0;
          idx_s   = skip_s ? 2'd1 : 2'd0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          bit_s   = 3'd0;
          state_s = DATA;
        end else begin
          baud_s = baud_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_s = '0;
          if (bit_r == 3'd7) begin
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      STOP: begin
        if (baud_r == BAUD_LAST) begin
          baud_s = '0;
          if (idx_r == 2'd2) begin
            state_s = IDLE;
            idx_s   = 2'd0;
          end else begin
            state_s = START;
            idx_s   = idx_r + 2'd1;
          end
        end else begin
          baud_s = baud_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = '0;
        bit_s   = 3'd0;
        idx_s   = 2'd0;
      end
    endcase

    cur_byte_s = byte_sel(idx_s, status_r, d1_r, d2_r);
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = cur_byte_s[bit_s];
      default: tx_s = 1'b1;
    endcase
  end

  // State, counters, registered outputs and command capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      baud_r        <= '0;
      bit_r         <= 3'd0;
      idx_r         <= 2'd0;
      tx_r          <= 1'b1;
      ready_r       <= 1'b1;
      busy_r        <= 1'b0;
      status_r      <= 8'h00;
      d1_r          <= 7'h00;
      d2_r          <= 7'h00;
      last_status_r <= 8'h00;
      last_valid_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      idx_r   <= idx_s;
      tx_r    <= tx_s;
      ready_r <= (state_s == IDLE);
      busy_r  <= (state_s != IDLE);
      if (accept_s) begin
        status_r      <= new_status_s;
        d1_r          <= cmd_d1;
        d2_r          <= cmd_d2;
        last_status_r <= new_status_s;
        last_valid_r  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- MIDI transmit path: accepts one channel-voice command (note-on / note-off, channel, key, velocity) per valid/ready handshake.
- Builds the 2- or 3-byte MIDI message and serialises it as 8N1 UART at 31250 baud on a single tx line.
- Optional running status suppresses repeated status bytes.
- Sits between the synth/sequencer control logic and the MIDI OUT pin, mirroring the receive-side datapath/controller pair.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 31250, serial bit rate.
- RUNNING_STATUS, 1, 1 = omit the status byte when it equals the last status byte sent; 0 = always send the status byte.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_note_on  input  1  1 = note-on (0x9n), 0 = note-off (0x8n).
- cmd_ch  input  4  MIDI channel n.
- cmd_d1  input  7  key number (data byte 1).
- cmd_d2  input  7  velocity (data byte 2).
- tx  output  1  serial MIDI out, idles high.
- busy  output  1  message in progress (equals !cmd_ready).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: tx=1, cmd_ready=1, busy=0, FSM=IDLE, baud counter=0, bit counter=0, byte index=0, last-status register invalid.
- Reset asserted mid-frame aborts immediately; tx returns high asynchronously. No partial byte resumes after reset.
- DIV = CLK_FREQ/BAUD, truncated (1600 at defaults). DIV must be at least 2. Every bit lasts exactly DIV clocks.
- Handshake: accept occurs on a cycle with cmd_valid && cmd_ready.
  - cmd_ready is high only in IDLE.
  - On accept, cmd_note_on/ch/d1/d2 are captured into internal registers. Inputs may change afterwards.
  - cmd_valid while busy is ignored and not queued.
- Status byte = {1, 0, 0, cmd_note_on, cmd_ch}, i.e. 0x80|ch or 0x90|ch. Data bytes = {0, d}. Bit 7 of a data byte is always 0.
- Running status: when RUNNING_STATUS=1, last status is valid, and the new status equals last status, the message is data1 then data2 only. Otherwise status, data1, data2 are sent.
  - Last status is updated with the new status byte at accept.
  - Last status becomes valid after the first message and is invalidated only by reset.
- FSM states:
  - IDLE: tx=1. On accept → START with byte index pointing at the first byte to send.
  - START: tx=0 for DIV clocks → DATA.
  - DATA: 8 bits, LSB first, DIV clocks each → STOP.
  - STOP: tx=1 for DIV clocks. If more bytes remain, advance byte index → START. Otherwise → IDLE.
- Bytes are sent back-to-back with no idle gap between the stop bit and the next start bit.
- Latency: tx falls on the first rising edge after the accept edge, i.e. the START state is registered.
  - Full message = 30·DIV clocks (3 bytes) or 20·DIV clocks (2 bytes) from that edge to the return to IDLE.
  - cmd_ready rises in the cycle the FSM re-enters IDLE. A new command may be accepted in that same cycle, so the minimum gap between messages is 1 clock of idle-high.
- tx is driven from a flop (glitch-free).
- Note-on with velocity 0 is sent verbatim as 0x9n with d2=0. No conversion to 0x8n.

Test Plan (use CLK_FREQ=40, BAUD=10 → DIV=4 for speed):
- Note-on ch 3, d1=60, d2=100 after reset → tx bytes 0x93, 0x3C, 0x64, each framed 0 + LSB-first + 1. 120 clocks busy; tx low on the clock after accept; cmd_ready back high at clock 120.
- Second note-on ch 3, d1=62, d2=80, RUNNING_STATUS=1 → only 0x3E, 0x50 sent; 80 clocks busy. With RUNNING_STATUS=0 → 0x93, 0x3E, 0x50 sent.
- Note-off ch 3 following a note-on ch 3 → status changes, so 0x83, d1, d2 sent. Then note-on ch 4 → 0x94 sent.
- cmd_valid held high through an entire message with changing data → the first command is sent unaltered. The second command is accepted on the exact cycle cmd_ready returns high, and its start bit follows one idle-high clock.
- rst pulsed during the DATA bit 3 of the second byte → tx=1 and cmd_ready=1 immediately. The next identical command resends the status byte, because last status was invalidated.
- Velocity 0 note-on ch 0, d1=0x7F → bytes 0x90, 0x7F, 0x00. Bit 7 of every data byte is observed as 0.
